// File: rtl/vga_scan.sv
// 640x480@60 raster timing around the compositor: x/y out, delayed colour/sync in-out, blanking.
// Optional VGA_SCAN_TESTPAT_EN replaces pix_in with eight vertical colour bars.
module vga_scan #(
  parameter int CLK_DIV = 4,
  parameter int PIX_LAT = 1,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pix_in,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        video_on,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int PIPE_D = (PIX_LAT > 0) ? PIX_LAT : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

`ifdef VGA_SCAN_TESTPAT_EN
  localparam int PW = 6;
  localparam logic [9:0] BAR_W = 10'(H_VIS / 8);
`else
  localparam int PW = 3;
`endif

  // Pipeline idle word: not visible, both syncs deasserted (high).
  localparam logic [PW-1:0] PIPE_IDLE = PW'(3'b011);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             act;
  logic             hs_raw;
  logic             vs_raw;
  logic [PW-1:0]    raw;
  logic [PW-1:0]    tail;
  logic [11:0]      rgb_src;

  assign tick = (div == DIV_LAST);

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Timing flags describe the position currently shown on x/y, so they line up with pix_in.
  assign act    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

`ifdef VGA_SCAN_TESTPAT_EN
  logic [9:0] bar_full;
  assign bar_full = h_cnt / BAR_W;
  assign raw      = {bar_full[2:0], act, hs_raw, vs_raw};

  always_comb begin
    case (tail[5:3])
      3'd0:    rgb_src = 12'hFFF;
      3'd1:    rgb_src = 12'hFF0;
      3'd2:    rgb_src = 12'h0FF;
      3'd3:    rgb_src = 12'h0F0;
      3'd4:    rgb_src = 12'hF0F;
      3'd5:    rgb_src = 12'hF00;
      3'd6:    rgb_src = 12'h00F;
      default: rgb_src = 12'h000;
    endcase
  end
`else
  assign raw     = {act, hs_raw, vs_raw};
  assign rgb_src = pix_in;
`endif

  generate
    if (PIX_LAT == 0) begin : g_no_pipe
      assign tail = raw;
    end else begin : g_pipe
      logic [PIPE_D-1:0][PW-1:0] pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_D; i++) pipe[i] <= PIPE_IDLE;
        end else if (tick) begin
          pipe[0] <= raw;
          for (int i = 1; i < PIPE_D; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign tail = pipe[PIPE_D-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      {r, g, b}   <= 12'h000;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      frame_start <= 1'b0;
      if (tick) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        x           <= (h_nxt < H_VIS_C) ? h_nxt : 10'd0;
        y           <= (v_nxt < V_VIS_C) ? v_nxt[8:0] : 9'd0;
        frame_start <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
        video_on    <= tail[2];
        hs          <= tail[1];
        vs          <= tail[0];
        {r, g, b}   <= tail[2] ? rgb_src : 12'h000;
      end
    end
  end

endmodule
